// File: rtl/game_pkg.sv
// Shared types and constants for the board-game turn controller.
//   TILE_W       : width of a tile index
//   GOAL_TILE    : last tile on the default 16-tile board
//   game_state_t : controller states
//   advance_tile : position after a roll, clamped at the goal tile
package game_pkg;

    localparam int unsigned TILE_W = 4;
    localparam logic [TILE_W-1:0] GOAL_TILE = 4'd15;

    typedef enum logic [2:0] {
        ST_INTRO,
        ST_WAIT_DICE,
        ST_MOVE,
        ST_ANIM,
        ST_WIN
    } game_state_t;

    // Sum is formed one bit wider so 15 + 6 cannot wrap before the clamp.
    function automatic logic [TILE_W-1:0] advance_tile(
        input logic [TILE_W-1:0] pos,
        input logic [2:0]        pips,
        input logic [TILE_W-1:0] goal
    );
        logic [TILE_W:0] sum;
        sum = (TILE_W+1)'(pos) + (TILE_W+1)'(pips);
        if (sum >= (TILE_W+1)'(goal)) begin
            return goal;
        end
        return sum[TILE_W-1:0];
    endfunction

endpackage

// File: rtl/anim_watchdog.sv
// Cycle watchdog for the move animation.
//   clk, reset : clock and synchronous active-high reset
//   clr        : clear the count to zero (held while not animating)
//   en         : count while high
//   expired    : high in the cycle the count reaches TIMEOUT-1 while enabled
module anim_watchdog #(
    parameter int unsigned TIMEOUT = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired = en && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_turn_controller.sv
// Two-player board-game turn controller: intro menu, dice acceptance,
// clamped move, animation wait with watchdog, and win/restart handling.
//   clk, reset     : clock and synchronous active-high reset
//   start_req      : intro "START GAME" pulse
//   restart_req    : return-to-intro pulse, honoured only after a win
//   dice_valid     : fresh dice recognition pulse, dice_value = pips (1..6 legal)
//   turn_done      : renderer finished the move animation
//   is_intro_state : high while in the intro menu
//   p1_pos, p2_pos : player tile indices
//   pos_valid      : one-cycle pulse when a position register is written by a move
//   winner_valid   : level, a winner exists; winner = 0 P1 / 1 P2
//   turn           : active player, 0 P1 / 1 P2
module game_turn_controller
    import game_pkg::*;
#(
    parameter int unsigned NUM_TILES    = 16,
    parameter int unsigned ANIM_TIMEOUT = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_req,
    input  logic              restart_req,
    input  logic              dice_valid,
    input  logic [2:0]        dice_value,
    input  logic              turn_done,
    output logic              is_intro_state,
    output logic [TILE_W-1:0] p1_pos,
    output logic [TILE_W-1:0] p2_pos,
    output logic              pos_valid,
    output logic              winner_valid,
    output logic              winner,
    output logic              turn
);

    localparam logic [TILE_W-1:0] GOAL = TILE_W'(NUM_TILES - 1);

    game_state_t       state_q, state_d;
    logic [TILE_W-1:0] p1_pos_q, p1_pos_d;
    logic [TILE_W-1:0] p2_pos_q, p2_pos_d;
    logic [2:0]        dice_q, dice_d;
    logic              turn_q, turn_d;
    logic              winner_q, winner_d;
    logic              winner_valid_q, winner_valid_d;
    logic              pos_valid_q, pos_valid_d;
    logic              is_intro_q, is_intro_d;
    logic [TILE_W-1:0] move_pos;
    logic              anim_expired;

    // Count is held at zero outside ANIM, so it always starts from 0 on entry.
    anim_watchdog #(
        .TIMEOUT (ANIM_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != ST_ANIM),
        .en      (state_q == ST_ANIM),
        .expired (anim_expired)
    );

    always_comb begin
        state_d        = state_q;
        p1_pos_d       = p1_pos_q;
        p2_pos_d       = p2_pos_q;
        dice_d         = dice_q;
        turn_d         = turn_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        pos_valid_d    = 1'b0;
        move_pos       = advance_tile(turn_q ? p2_pos_q : p1_pos_q, dice_q, GOAL);

        case (state_q)
            ST_INTRO: begin
                if (start_req) begin
                    state_d        = ST_WAIT_DICE;
                    p1_pos_d       = '0;
                    p2_pos_d       = '0;
                    turn_d         = 1'b0;
                    winner_d       = 1'b0;
                    winner_valid_d = 1'b0;
                end
            end
            ST_WAIT_DICE: begin
                if (dice_valid && (dice_value != 3'd0) && (dice_value != 3'd7)) begin
                    dice_d  = dice_value;
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (turn_q) begin
                    p2_pos_d = move_pos;
                end else begin
                    p1_pos_d = move_pos;
                end
                pos_valid_d = 1'b1;
                if (move_pos == GOAL) begin
                    winner_valid_d = 1'b1;
                    winner_d       = turn_q;
                end
                state_d = ST_ANIM;
            end
            ST_ANIM: begin
                // turn_done and expiry together still make one transition.
                if (turn_done || anim_expired) begin
                    if (winner_valid_q) begin
                        state_d = ST_WIN;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = ST_WAIT_DICE;
                    end
                end
            end
            ST_WIN: begin
                if (restart_req) begin
                    state_d        = ST_INTRO;
                    p1_pos_d       = '0;
                    p2_pos_d       = '0;
                    turn_d         = 1'b0;
                    winner_d       = 1'b0;
                    winner_valid_d = 1'b0;
                end
            end
            default: state_d = ST_INTRO;
        endcase

        is_intro_d = (state_d == ST_INTRO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INTRO;
            p1_pos_q       <= '0;
            p2_pos_q       <= '0;
            dice_q         <= '0;
            turn_q         <= 1'b0;
            winner_q       <= 1'b0;
            winner_valid_q <= 1'b0;
            pos_valid_q    <= 1'b0;
            is_intro_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            p1_pos_q       <= p1_pos_d;
            p2_pos_q       <= p2_pos_d;
            dice_q         <= dice_d;
            turn_q         <= turn_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
            pos_valid_q    <= pos_valid_d;
            is_intro_q     <= is_intro_d;
        end
    end

    assign is_intro_state = is_intro_q;
    assign p1_pos         = p1_pos_q;
    assign p2_pos         = p2_pos_q;
    assign pos_valid      = pos_valid_q;
    assign winner_valid   = winner_valid_q;
    assign winner         = winner_q;
    assign turn           = turn_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller with a cycle-level game model.
module tb_game_turn_controller;

    localparam int NT = 16;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_req = 1'b0;
    logic       restart_req = 1'b0;
    logic       dice_valid = 1'b0;
    logic [2:0] dice_value = 3'd0;
    logic       turn_done = 1'b0;
    logic       is_intro_state;
    logic [3:0] p1_pos, p2_pos;
    logic       pos_valid, winner_valid, winner, turn;

    game_turn_controller #(
        .NUM_TILES    (NT),
        .ANIM_TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_req      (start_req),
        .restart_req    (restart_req),
        .dice_valid     (dice_valid),
        .dice_value     (dice_value),
        .turn_done      (turn_done),
        .is_intro_state (is_intro_state),
        .p1_pos         (p1_pos),
        .p2_pos         (p2_pos),
        .pos_valid      (pos_valid),
        .winner_valid   (winner_valid),
        .winner         (winner),
        .turn           (turn)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic       s_reset, s_start, s_restart, s_dv, s_td;
    logic [2:0] s_dval;
    always @(posedge clk) begin
        s_reset   <= reset;
        s_start   <= start_req;
        s_restart <= restart_req;
        s_dv      <= dice_valid;
        s_dval    <= dice_value;
        s_td      <= turn_done;
    end

    // Game model: phase names follow the game rules, positions are plain ints.
    localparam int PH_MENU = 0, PH_ROLL = 1, PH_STEP = 2, PH_SHOW = 3, PH_OVER = 4;
    int m_phase = PH_MENU;
    int m_pos[2] = '{0, 0};
    int m_turn = 0, m_wv = 0, m_winner = 0, m_pv = 0, m_roll = 0, m_age = 0;

    task automatic model_step();
        int np;
        if (s_reset) begin
            m_phase = PH_MENU; m_pos[0] = 0; m_pos[1] = 0;
            m_turn = 0; m_wv = 0; m_winner = 0; m_pv = 0; m_age = 0;
            return;
        end
        m_pv = 0;
        case (m_phase)
            PH_MENU: if (s_start) begin
                m_phase = PH_ROLL; m_pos[0] = 0; m_pos[1] = 0; m_turn = 0; m_wv = 0;
            end
            PH_ROLL: if (s_dv && s_dval >= 1 && s_dval <= 6) begin
                m_roll = int'(s_dval); m_phase = PH_STEP;
            end
            PH_STEP: begin
                np = m_pos[m_turn] + m_roll;
                if (np > NT - 1) np = NT - 1;
                m_pos[m_turn] = np;
                m_pv = 1;
                if (np == NT - 1) begin m_wv = 1; m_winner = m_turn; end
                m_phase = PH_SHOW; m_age = 0;
            end
            PH_SHOW: begin
                if (s_td || m_age == TO - 1) begin
                    if (m_wv != 0) m_phase = PH_OVER;
                    else begin m_turn = 1 - m_turn; m_phase = PH_ROLL; end
                end else m_age++;
            end
            PH_OVER: if (s_restart) begin
                m_phase = PH_MENU; m_pos[0] = 0; m_pos[1] = 0; m_turn = 0; m_wv = 0;
            end
            default: m_phase = PH_MENU;
        endcase
    endtask

    always @(negedge clk) begin
        model_step();
        check("is_intro_state", is_intro_state, (m_phase == PH_MENU) ? 1 : 0);
        check("p1_pos", p1_pos, m_pos[0]);
        check("p2_pos", p2_pos, m_pos[1]);
        check("pos_valid", pos_valid, m_pv);
        check("winner_valid", winner_valid, m_wv);
        check("turn", turn, m_turn);
        if (m_wv != 0) check("winner", winner, m_winner);
    end

    task automatic pulse_start();
        @(negedge clk); #1 start_req = 1'b1;
        @(negedge clk); #1 start_req = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk); #1 restart_req = 1'b1;
        @(negedge clk); #1 restart_req = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); #1 turn_done = 1'b1;
        @(negedge clk); #1 turn_done = 1'b0;
    endtask

    task automatic roll(input logic [2:0] v);
        @(negedge clk); #1 dice_valid = 1'b1; dice_value = v;
        @(negedge clk); #1 dice_valid = 1'b0; dice_value = 3'd0;
    endtask

    task automatic full_turn(input logic [2:0] v);
        roll(v);
        @(negedge clk);
        pulse_done();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset is_intro", is_intro_state, 1);
        check("reset p1_pos", p1_pos, 0);
        check("reset pos_valid", pos_valid, 0);
        check("reset winner_valid", winner_valid, 0);
        #1 reset = 1'b0;

        // Dice and turn_done in the intro menu do nothing.
        roll(3'd3);
        pulse_done();
        check("intro ignores dice", p1_pos, 0);
        pulse_start();

        // P1 rolls 4: pos_valid two cycles after the dice pulse.
        roll(3'd4);
        @(negedge clk);
        check("p1 roll4 pos_valid", pos_valid, 1);
        check("p1 roll4 p1_pos", p1_pos, 4);
        check("p1 roll4 turn", turn, 0);
        pulse_done();
        check("turn after done", turn, 1);

        // Illegal pip values and a stray turn_done are dropped.
        roll(3'd0);
        roll(3'd7);
        pulse_done();
        repeat (3) @(negedge clk);
        check("illegal dice p2_pos", p2_pos, 0);
        check("illegal dice turn", turn, 1);

        // Dice during the animation is not queued.
        roll(3'd6);
        @(negedge clk);
        roll(3'd2);
        pulse_start();
        pulse_done();
        repeat (4) @(negedge clk);
        check("anim dice p2_pos", p2_pos, 6);
        check("anim dice turn", turn, 0);

        full_turn(3'd1);   // P1 -> 5
        full_turn(3'd6);   // P2 -> 12
        full_turn(3'd1);   // P1 -> 6
        full_turn(3'd1);   // P2 -> 13
        full_turn(3'd2);   // P1 -> 8
        check("pre-win p2_pos", p2_pos, 13);
        check("pre-win p1_pos", p1_pos, 8);

        // P2 rolls 5 from 13: clamps to the goal and wins.
        roll(3'd5);
        @(negedge clk);
        check("win p2_pos", p2_pos, 15);
        check("win winner_valid", winner_valid, 1);
        check("win winner", winner, 1);
        pulse_restart();
        pulse_done();
        repeat (3) @(negedge clk);
        check("win hold turn", turn, 1);
        check("win hold intro", is_intro_state, 0);
        pulse_start();
        check("win ignores start", winner_valid, 1);
        pulse_restart();
        check("restart intro", is_intro_state, 1);
        check("restart p2_pos", p2_pos, 0);
        check("restart winner_valid", winner_valid, 0);

        // Second game: watchdog timeouts.
        pulse_start();
        full_turn(3'd3);   // P1 -> 3
        roll(3'd2);        // P2 -> 2, no turn_done
        @(negedge clk);
        repeat (15) @(negedge clk);
        check("timeout not yet", turn, 1);
        @(negedge clk);
        check("timeout toggles", turn, 0);

        // turn_done in the same cycle as expiry: exactly one toggle.
        roll(3'd5);        // P1 -> 8
        @(negedge clk);
        repeat (15) @(negedge clk);
        #1 turn_done = 1'b1;
        @(negedge clk);
        #1 turn_done = 1'b0;
        check("coincident toggle", turn, 1);
        repeat (2) @(negedge clk);
        check("coincident single", turn, 1);
        check("coincident p1_pos", p1_pos, 8);

        // Reset during MOVE aborts the turn with no pos_valid.
        roll(3'd4);
        reset = 1'b1;
        @(negedge clk);
        check("abort intro", is_intro_state, 1);
        check("abort pos_valid", pos_valid, 0);
        check("abort p1_pos", p1_pos, 0);
        check("abort p2_pos", p2_pos, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort no pulse", pos_valid, 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1, "time limit");
    end

endmodule
